framebuffer_arbiter: RTL and testbench

- Shares one single-port synchronous framebuffer RAM between the processor data bus (read/write) and the GPU pixel fetch port (read-only).
- Sits inside ProcessorDE0 between proc/gpu and the framebuffer RAM.
- Fixed GPU priority with a CPU anti-starvation limit.
- All memory-side outputs are registered; each access is a req/ack handshake.

---
 rtl/framebuffer_arbiter.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_framebuffer_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter
// Shares one single-port synchronous framebuffer RAM between the CPU data
// bus (read/write) and the GPU pixel fetch port (read-only).
//
// Each access is a three-cycle req/ack handshake:
//   IDLE  : arbitrate, latch the winner's command into the mem_* registers
//   ISSUE : mem_en=1 for exactly this cycle, the RAM samples the command
//   RESP  : RAM data is valid; it is registered into the owner's rdata and
//           the owner's ack pulses in the following cycle (back in IDLE).
//
// Arbitration on simultaneous requests:
//   default build        : fixed GPU priority; after MAX_GPU_BURST
//                          consecutive GPU grants made while the CPU waits,
//                          the CPU wins one grant.
//   ARB_ROUND_ROBIN_EN   : winners alternate via a last_owner register
//                          (reset value CPU, so the GPU wins the first tie).
//
// All memory-side and requester-side outputs come straight from flops.

module framebuffer_arbiter #(
  parameter int ADDR_W        = 11,
  parameter int DATA_W        = 16,
  parameter int MAX_GPU_BURST = 4
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,

  input  logic              gpu_req,
  input  logic [ADDR_W-1:0] gpu_addr,
  output logic [DATA_W-1:0] gpu_rdata,
  output logic              gpu_ack,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_GPU  = 2'd2
  } owner_t;

  // ---------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------
  state_t              state_q,     state_d;
  owner_t              owner_q,     owner_d;
  logic                mem_en_q,    mem_en_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                cpu_ack_q,   cpu_ack_d;
  logic                gpu_ack_q,   gpu_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   gpu_rdata_q, gpu_rdata_d;

  // Grant decision for the current IDLE cycle (meaningless elsewhere).
  logic                grant_cpu_s;
  logic                grant_gpu_s;

`ifdef ARB_ROUND_ROBIN_EN
  // Winner of the most recent grant; only ever OWN_CPU or OWN_GPU.
  owner_t              last_owner_q, last_owner_d;
`else
  // Counts GPU grants made while the CPU was kept waiting. A 4-bit counter
  // covers the whole legal MAX_GPU_BURST range of 1..15.
  localparam int                CNT_W       = 4;
  localparam logic [CNT_W-1:0]  BURST_LIMIT = CNT_W'(MAX_GPU_BURST);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

  logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
`endif

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------

  // Pick the winner among the current requests; a lone requester always wins.
  always_comb begin
    grant_cpu_s = 1'b0;
    grant_gpu_s = 1'b0;
    if (cpu_req && gpu_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (last_owner_q == OWN_CPU) begin
        grant_gpu_s = 1'b1;
      end else begin
        grant_cpu_s = 1'b1;
      end
`else
      if (starve_cnt_q == BURST_LIMIT) begin
        grant_cpu_s = 1'b1;
      end else begin
        grant_gpu_s = 1'b1;
      end
`endif
    end else if (cpu_req) begin
      grant_cpu_s = 1'b1;
    end else if (gpu_req) begin
      grant_gpu_s = 1'b1;
    end else begin
      grant_cpu_s = 1'b0;
      grant_gpu_s = 1'b0;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember who won the latest grant so the next tie goes the other way.
  always_comb begin
    last_owner_d = last_owner_q;
    if (state_q == ST_IDLE) begin
      if (grant_cpu_s) begin
        last_owner_d = OWN_CPU;
      end else if (grant_gpu_s) begin
        last_owner_d = OWN_GPU;
      end else begin
        last_owner_d = last_owner_q;
      end
    end else begin
      last_owner_d = last_owner_q;
    end
  end

  // last_owner register; CPU after reset so the GPU takes the first tie.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_owner_q <= OWN_CPU;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  // Starvation counter: bump on GPU grants while the CPU waits, clear once
  // the CPU is served or stops asking; saturate at the burst limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (state_q == ST_IDLE) begin
      if (grant_cpu_s || !cpu_req) begin
        starve_cnt_d = {CNT_W{1'b0}};
      end else if (grant_gpu_s && (starve_cnt_q != BURST_LIMIT)) begin
        starve_cnt_d = starve_cnt_q + CNT_ONE;
      end else begin
        starve_cnt_d = starve_cnt_q;
      end
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt_q <= {CNT_W{1'b0}};
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Access sequencer
  // ---------------------------------------------------------------------

  // Next-state and output-register logic of the IDLE/ISSUE/RESP sequencer.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    gpu_rdata_d = gpu_rdata_q;
    cpu_ack_d   = 1'b0;
    gpu_ack_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_cpu_s) begin
          state_d     = ST_ISSUE;
          owner_d     = OWN_CPU;
          mem_en_d    = 1'b1;
          mem_we_d    = cpu_we;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
        end else if (grant_gpu_s) begin
          // GPU fetches are read-only; write data is left as it was.
          state_d     = ST_ISSUE;
          owner_d     = OWN_GPU;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = gpu_addr;
        end else begin
          state_d     = ST_IDLE;
          owner_d     = OWN_NONE;
          mem_en_d    = 1'b0;
          mem_we_d    = 1'b0;
        end
      end

      ST_ISSUE: begin
        // The RAM takes the command at the end of this cycle.
        state_d  = ST_RESP;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end

      ST_RESP: begin
        // RAM data is valid now; hand it to the owner with a one-cycle ack.
        // For writes the captured word is the RAM's read-during-write value.
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
        if (owner_q == OWN_CPU) begin
          cpu_rdata_d = mem_rdata;
          cpu_ack_d   = 1'b1;
        end else if (owner_q == OWN_GPU) begin
          gpu_rdata_d = mem_rdata;
          gpu_ack_d   = 1'b1;
        end else begin
          cpu_ack_d   = 1'b0;
          gpu_ack_d   = 1'b0;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        owner_d  = OWN_NONE;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  // Sequencer and output registers; reset drops any access in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      cpu_ack_q   <= 1'b0;
      gpu_ack_q   <= 1'b0;
      cpu_rdata_q <= {DATA_W{1'b0}};
      gpu_rdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      gpu_ack_q   <= gpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      gpu_rdata_q <= gpu_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign gpu_ack   = gpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign gpu_rdata = gpu_rdata_q;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Directed bench for framebuffer_arbiter. A behavioural single-port RAM is
// attached; word i is preloaded with 16'hA500 ^ i, so reads of untouched
// low addresses return A5xx with xx = address.

module tb_framebuffer_arbiter;

  logic        clock;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [10:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;
  logic        gpu_req;
  logic [10:0] gpu_addr;
  logic [15:0] gpu_rdata;
  logic        gpu_ack;
  logic        mem_en;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  int n_total;
  int n_bad;

  framebuffer_arbiter #(
    .ADDR_W       (11),
    .DATA_W       (16),
    .MAX_GPU_BURST(4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ack  (cpu_ack),
    .gpu_req  (gpu_req),
    .gpu_addr (gpu_addr),
    .gpu_rdata(gpu_rdata),
    .gpu_ack  (gpu_ack),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural RAM: preload on the first edge, then read-first access.
  logic [15:0] ram [0:2047];
  logic        ram_init;
  initial ram_init = 1'b0;
  always @(posedge clock) begin
    if (!ram_init) begin
      for (int k = 0; k < 2048; k++) ram[k] <= 16'hA500 ^ 16'(k);
      ram_init  <= 1'b1;
      mem_rdata <= 16'h0000;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One CPU access; req dropped in the ack cycle. lat=0 means no ack seen.
  task automatic cpu_access(input logic we, input logic [10:0] addr, input logic [15:0] wd,
                            output logic [15:0] rd, output int lat, output int we_cyc,
                            output logic [10:0] iss_addr, output logic [15:0] iss_wdata);
    cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    lat = 0; we_cyc = 0; rd = 16'h0000; iss_addr = 11'h000; iss_wdata = 16'h0000;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (mem_we) we_cyc++;
      if (mem_en) begin iss_addr = mem_addr; iss_wdata = mem_wdata; end
      if (cpu_ack) begin
        lat = i; rd = cpu_rdata; cpu_req = 1'b0;
        break;
      end
    end
    cpu_req = 1'b0;
  endtask

  logic [15:0] rd;
  int          lat, we_cyc, n_ack, t_g, t_c, n_grant;
  logic [10:0] ia;
  logic [15:0] iw;
  logic [9:0]  exp_order;
  logic [9:0]  got_order;
  logic [15:0] cpu_rd_hold;

  initial begin
    n_total = 0; n_bad = 0;
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 11'h000; cpu_wdata = 16'h0000;
    gpu_req = 1'b0; gpu_addr = 11'h000;

    // ---- reset state ----
    tick(); tick();
    check_eq("rst_mem_en", 32'(mem_en), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check_eq("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check_eq("rst_gpu_ack", 32'(gpu_ack), 32'd0);
    check_eq("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check_eq("rst_gpu_rdata", 32'(gpu_rdata), 32'd0);
    reset = 1'b1;
    tick(); tick();

    // ---- reset mid-access ----
    cpu_we = 1'b0; cpu_addr = 11'h005; cpu_req = 1'b1;
    tick();
    check_eq("mid_issue_en", 32'(mem_en), 32'd1);
    check_eq("mid_issue_addr", 32'(mem_addr), 32'h005);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_en", 32'(mem_en), 32'd0);
    check_eq("mid_rst_addr", 32'(mem_addr), 32'd0);
    cpu_req = 1'b0;
    tick();
    reset = 1'b1;
    n_ack = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cpu_ack || gpu_ack) n_ack++;
    end
    check_eq("mid_no_ack", 32'(n_ack), 32'd0);
    cpu_access(1'b0, 11'h005, 16'h0000, rd, lat, we_cyc, ia, iw);
    check_eq("mid_next_lat", 32'(lat), 32'd3);
    check_eq("mid_next_rdata", 32'(rd), 32'hA505);
    tick();

    // ---- GPU-only stream 0x000..0x003 ----
    cpu_rd_hold = cpu_rdata;
    gpu_addr = 11'h000; gpu_req = 1'b1;
    n_ack = 0; t_g = 0;
    for (int i = 1; i <= 40 && n_ack < 4; i++) begin
      tick();
      if (cpu_ack) check_eq("gs_cpu_ack", 32'(cpu_ack), 32'd0);
      if (gpu_ack) begin
        check_eq($sformatf("gs_rdata%0d", n_ack), 32'(gpu_rdata), 32'(16'hA500 + 16'(n_ack)));
        check_eq($sformatf("gs_gap%0d", n_ack), 32'(i - t_g), 32'd3);
        t_g = i;
        n_ack++;
        if (n_ack == 4) gpu_req = 1'b0;
        else gpu_addr = 11'(n_ack);
      end
    end
    gpu_req = 1'b0;
    check_eq("gs_count", 32'(n_ack), 32'd4);
    check_eq("gs_cpu_rdata_hold", 32'(cpu_rdata), 32'(cpu_rd_hold));
    tick();

    // ---- CPU write then read ----
    cpu_access(1'b1, 11'h0A5, 16'h1234, rd, lat, we_cyc, ia, iw);
    check_eq("wr_lat", 32'(lat), 32'd3);
    check_eq("wr_we_cycles", 32'(we_cyc), 32'd1);
    check_eq("wr_addr", 32'(ia), 32'h0A5);
    check_eq("wr_wdata", 32'(iw), 32'h1234);
    cpu_access(1'b0, 11'h0A5, 16'h0000, rd, lat, we_cyc, ia, iw);
    check_eq("rd_lat", 32'(lat), 32'd3);
    check_eq("rd_we_cycles", 32'(we_cyc), 32'd0);
    check_eq("rd_rdata", 32'(rd), 32'h1234);
    tick();

    // ---- simultaneous single requests ----
    cpu_we = 1'b0; cpu_addr = 11'h0A5; cpu_req = 1'b1;
    gpu_addr = 11'h003; gpu_req = 1'b1;
    t_g = 0; t_c = 0;
    for (int i = 1; i <= 30 && t_c == 0; i++) begin
      tick();
      if (gpu_ack) begin
        t_g = i; gpu_req = 1'b0;
        check_eq("sim_gpu_rdata", 32'(gpu_rdata), 32'hA503);
      end
      if (cpu_ack) begin
        t_c = i; cpu_req = 1'b0;
        check_eq("sim_cpu_rdata", 32'(cpu_rdata), 32'h1234);
      end
    end
    cpu_req = 1'b0; gpu_req = 1'b0;
    check_eq("sim_gpu_lat", 32'(t_g), 32'd3);
    check_eq("sim_cpu_gap", 32'(t_c - t_g), 32'd3);
    tick();

    // ---- both requesters held: grant order ----
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = 10'b1010101010;
`else
    exp_order = 10'b1000010000;
`endif
    got_order = 10'h000;
    cpu_we = 1'b0; cpu_addr = 11'h010; cpu_req = 1'b1;
    gpu_addr = 11'h020; gpu_req = 1'b1;
    n_grant = 0;
    for (int i = 1; i <= 60 && n_grant < 10; i++) begin
      tick();
      if (cpu_ack && gpu_ack) check_eq("both_ack", 32'd1, 32'd0 + 32'(cpu_ack ^ gpu_ack));
      if (cpu_ack || gpu_ack) begin
        got_order[n_grant] = cpu_ack;
        if (cpu_ack) check_eq("ord_cpu_rdata", 32'(cpu_rdata), 32'hA510);
        else check_eq("ord_gpu_rdata", 32'(gpu_rdata), 32'hA520);
        n_grant++;
        if (n_grant == 10) begin cpu_req = 1'b0; gpu_req = 1'b0; end
      end
    end
    cpu_req = 1'b0; gpu_req = 1'b0;
    check_eq("ord_count", 32'(n_grant), 32'd10);
    check_eq("ord_sequence", 32'(got_order), 32'(exp_order));
    tick(); tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
